// File: rtl/nano_ifetch.sv
// Instruction prefetch stage: sequential word fetch over a req/ack memory port,
// buffered in a small FIFO and presented to the core with valid/ready.
module nano_ifetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        not_reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StFlush} state_e;

    state_e          state_q, state_d;
    logic [31:0]     fpc_q, fpc_d;
    logic [31:0]     addr_q, addr_d;
    logic            req_q, req_d;
    logic            valid_q, valid_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     data_mem_q [DEPTH];
    logic [31:0]     pc_mem_q   [DEPTH];

    logic ack, push, pop;

    always_comb begin
        ack  = req_q && mem_ack;
        // Redirect discards both the returning word and the core's pop this cycle.
        push = ack && (state_q == StReq) && !redirect;
        pop  = valid_q && inst_ready && !redirect;

        state_d  = state_q;
        fpc_d    = fpc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            fpc_d    = redirect_pc & 32'hFFFF_FFFC;
            case (state_q)
                StIdle:  state_d = StReq;
                StReq:   state_d = ack ? StReq : StFlush;
                StFlush: state_d = StFlush;
                default: state_d = StIdle;
            endcase
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            count_d = count_q + CntW'(push) - CntW'(pop);
            case (state_q)
                StIdle: begin
                    if (count_q < DepthC) state_d = StReq;
                end
                StReq: begin
                    if (ack) begin
                        fpc_d   = fpc_q + 32'd4;
                        state_d = (count_d < DepthC) ? StReq : StIdle;
                    end
                end
                StFlush: begin
                    if (ack) state_d = StReq;
                end
                default: state_d = StIdle;
            endcase
        end

        // Address only moves when a fresh request starts; FLUSH keeps the old one.
        req_d   = (state_d != StIdle);
        addr_d  = (state_d == StReq) ? fpc_d : addr_q;
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clock) begin
        if (!not_reset) begin
            state_q  <= StIdle;
            fpc_q    <= RESET_PC;
            addr_q   <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push) begin
                data_mem_q[wr_ptr_q] <= mem_rdata;
                pc_mem_q[wr_ptr_q]   <= fpc_q;
            end
        end
    end

    assign mem_req    = req_q;
    assign mem_addr   = addr_q;
    assign inst_valid = valid_q;
    assign inst_data  = data_mem_q[rd_ptr_q];
    assign inst_pc    = pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_nano_ifetch.sv
// Directed bench for nano_ifetch; memory returns ~address so data tracks PC.
module tb_nano_ifetch;

    logic        clock;
    logic        not_reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int n_cmp = 0;
    int n_err = 0;

    nano_ifetch #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock       (clock),
        .not_reset   (not_reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    assign mem_rdata = ~mem_addr;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Checks the head entry: PC and the word the memory model returns for it.
    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
        chk({tag, "_pc"}, inst_pc, pc);
        chk({tag, "_data"}, inst_data, ~pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        not_reset   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        mem_ack     = 1'b0;
        inst_ready  = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_req",   {31'd0, mem_req}, 32'd0);
        chk("rst_addr",  mem_addr, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_data",  inst_data, 32'd0);
        chk("rst_pc",    inst_pc, 32'd0);

        // Zero-wait streaming
        mem_ack    = 1'b1;
        inst_ready = 1'b1;
        not_reset  = 1'b1;
        tick();
        chk("s_req0",   {31'd0, mem_req}, 32'd1);
        chk("s_addr0",  mem_addr, 32'd0);
        chk("s_valid0", {31'd0, inst_valid}, 32'd0);
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("s_addr", mem_addr, 32'(4 * (i + 1)));
            chk_head("s_head", 32'(4 * i));
            tick();
        end

        // Back-pressure fills exactly DEPTH entries
        not_reset  = 1'b0;
        inst_ready = 1'b0;
        tick();
        chk("bp_rst_valid", {31'd0, inst_valid}, 32'd0);
        not_reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_addr", mem_addr, 32'(4 * i));
            chk("bp_req", {31'd0, mem_req}, 32'd1);
        end
        tick();
        chk("bp_full_req", {31'd0, mem_req}, 32'd0);
        chk_head("bp_full", 32'h0);
        tick();
        tick();
        chk("bp_hold_req", {31'd0, mem_req}, 32'd0);
        chk_head("bp_hold", 32'h0);
        inst_ready = 1'b1;
        tick();
        chk("bp_r1_req", {31'd0, mem_req}, 32'd0);
        chk_head("bp_r1", 32'h4);
        tick();
        chk("bp_r2_req", {31'd0, mem_req}, 32'd1);
        chk("bp_r2_addr", mem_addr, 32'h10);
        chk_head("bp_r2", 32'h8);
        tick();
        chk("bp_r3_addr", mem_addr, 32'h14);
        chk_head("bp_r3", 32'hC);
        tick();
        chk_head("bp_r4", 32'h10);
        tick();
        chk_head("bp_r5", 32'h14);

        // Slow memory with redirect while request is outstanding
        not_reset = 1'b0;
        mem_ack   = 1'b0;
        tick();
        not_reset = 1'b1;
        tick();
        chk("fl_req0", {31'd0, mem_req}, 32'd1);
        chk("fl_addr0", mem_addr, 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        chk("fl_hold1_req", {31'd0, mem_req}, 32'd1);
        chk("fl_hold1_addr", mem_addr, 32'h0);
        chk("fl_hold1_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        chk("fl_hold2_addr", mem_addr, 32'h0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("fl_new_req", {31'd0, mem_req}, 32'd1);
        chk("fl_new_addr", mem_addr, 32'h100);
        chk("fl_drop_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        tick();
        chk("fl_wait_addr", mem_addr, 32'h100);
        chk("fl_wait_valid", {31'd0, inst_valid}, 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk_head("fl_first", 32'h100);
        chk("fl_next_addr", mem_addr, 32'h104);

        // Redirect coincident with ack and pop, two entries buffered
        not_reset  = 1'b0;
        inst_ready = 1'b0;
        tick();
        not_reset = 1'b1;
        mem_ack   = 1'b1;
        tick();
        tick();
        tick();
        chk_head("co_pre", 32'h0);
        chk("co_pre_addr", mem_addr, 32'h8);
        inst_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        tick();
        redirect = 1'b0;
        chk("co_valid", {31'd0, inst_valid}, 32'd0);
        chk("co_req", {31'd0, mem_req}, 32'd1);
        chk("co_addr", mem_addr, 32'h40);
        tick();
        chk_head("co_first", 32'h40);
        chk("co_next_addr", mem_addr, 32'h44);

        // PC wrap-around
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        chk("wr_addr", mem_addr, 32'hFFFF_FFF8);
        chk("wr_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        chk_head("wr_h0", 32'hFFFF_FFF8);
        chk("wr_addr1", mem_addr, 32'hFFFF_FFFC);
        tick();
        chk_head("wr_h1", 32'hFFFF_FFFC);
        chk("wr_addr2", mem_addr, 32'h0);
        tick();
        chk_head("wr_h2", 32'h0);

        // Reset with a request pending and three entries buffered
        inst_ready = 1'b0;
        tick();
        tick();
        mem_ack = 1'b0;
        chk_head("rr_pre", 32'h0);
        chk("rr_pre_req", {31'd0, mem_req}, 32'd1);
        chk("rr_pre_addr", mem_addr, 32'hC);
        tick();
        chk("rr_wait_req", {31'd0, mem_req}, 32'd1);
        not_reset = 1'b0;
        tick();
        chk("rr_req", {31'd0, mem_req}, 32'd0);
        chk("rr_valid", {31'd0, inst_valid}, 32'd0);
        chk("rr_addr", mem_addr, 32'h0);
        not_reset  = 1'b1;
        mem_ack    = 1'b1;
        inst_ready = 1'b1;
        tick();
        chk("rr_restart_req", {31'd0, mem_req}, 32'd1);
        chk("rr_restart_addr", mem_addr, 32'h0);
        tick();
        chk_head("rr_first", 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nano_ifetch.md
Name: nano_ifetch

Overview:
Instruction prefetch stage sitting directly upstream of the nanoCPU core. It generates sequential word addresses toward a variable-latency program memory using a req/ack handshake, and buffers returned words with their PCs in a small FIFO. It presents instructions to the core with a valid/ready handshake. A redirect input (branch/jump target from the core) flushes the buffer and restarts fetch at the new PC.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
RESET_PC, 32'h0000_0000, fetch PC loaded on reset (word aligned)

Ports:
clock  input  1  system clock, all state updates on rising edge
not_reset  input  1  synchronous active-low reset; state cleared on a rising clock edge while low
redirect  input  1  core requests fetch restart at redirect_pc
redirect_pc  input  32  new fetch PC; bits [1:0] ignored and forced to 0
mem_req  output  1  program-memory request valid
mem_addr  output  32  program-memory word address (byte address, [1:0]=0)
mem_ack  input  1  memory completes transfer this cycle
mem_rdata  input  32  instruction word; sampled when mem_req && mem_ack
inst_valid  output  1  FIFO head holds a valid instruction
inst_data  output  32  instruction at FIFO head
inst_pc  output  32  PC of inst_data
inst_ready  input  1  core consumes head when inst_valid && inst_ready

Behaviour:
- Reset (not_reset low at edge): fpc=RESET_PC, FIFO empty, count=0, state IDLE; mem_req=0, mem_addr=0, inst_valid=0, inst_data=0, inst_pc=0. Reset overrides everything, including an in-flight request (mem_req drops at that edge; memory is reset by the same signal).
- At most one outstanding request. Transfer completes in any cycle with mem_req && mem_ack; ack in the same cycle as req assertion is legal (zero-wait memory).
- Once asserted, mem_req and mem_addr are held stable until ack.
- FSM states:
  - IDLE: mem_req=0. Go to REQ when count<DEPTH (slot free).
  - REQ: mem_req=1, mem_addr=fpc. On ack, push {fpc, mem_rdata} and fpc+=4. If the FIFO still has a free slot after this cycle's push/pop, stay in REQ with the next address (back-to-back, 1 word/cycle with zero-wait memory); otherwise go to IDLE.
  - FLUSH: entered on redirect while in REQ without ack that cycle. Keep mem_req=1 and the old mem_addr until ack, then discard mem_rdata. Next state is REQ at the redirected fpc.
- Redirect priority is highest (below reset). The FIFO is emptied that edge, fpc={redirect_pc[31:2],2'b00}, and any pop or ack data that cycle is discarded. Next state:
  - From IDLE: REQ.
  - From REQ with ack the same cycle: REQ.
  - From REQ without ack: FLUSH.
  - From FLUSH: stays FLUSH with the updated target.
- inst_valid = count!=0, registered with FIFO state; inst_data and inst_pc show the head entry. Pop and push may occur in the same cycle; count is unchanged.
- Pop when empty is ignored. Push never occurs when full, because a request is issued only with a slot free.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0.
- The head entry holds stable while inst_valid && !inst_ready.
- Latency: with zero-wait memory, the first instruction after reset or redirect is valid 2 cycles after the request edge (request cycle, then push edge).

Test Plan:
- Reset release, mem_ack tied 1, inst_ready=1 -> mem_addr 0,4,8,... on consecutive cycles; inst_pc/inst_data stream in order with no gaps; inst_valid=0 during reset.
- inst_ready=0, mem_ack=1 -> exactly DEPTH=4 words fetched (addr 0..12); mem_req=0 afterwards; asserting inst_ready resumes fetch at 16 with no loss or duplication.
- Memory with 3-cycle ack latency, redirect to 32'h0000_0103 one cycle after request to 0 -> mem_addr held at 0 until ack, that data dropped, next request at 0x100; the first inst_pc seen is 0x100.
- Redirect coincident with ack and pop while FIFO holds 2 entries -> FIFO empty next cycle, inst_valid=0, next mem_addr = redirect target.
- Redirect to 32'hFFFF_FFF8, mem_ack=1 -> inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- not_reset pulled low while a request awaits ack with 3 entries buffered -> next cycle mem_req=0, inst_valid=0; after release, fetch restarts at RESET_PC.
